// File: rtl/pl_io_display.sv
// CPU output registers shown as decimal 7-seg digits via a round-robin double-dabble engine,
// plus two-flop synchronised input ports. Define IO_DISP_BLANK_EN for leading-zero blanking.
module pl_io_display #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DIGITS = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned IN_W   = 5,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DW-1:0]           rd_data,
    input  logic [NCH*IN_W-1:0]     in_data,
    output logic [NCH*DIGITS*7-1:0] seg,
    output logic [NCH-1:0]          ovf,
    output logic                    frame_done
);
    localparam int unsigned CONV_W = $clog2(10**DIGITS);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned PTR_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CNT_W  = $clog2(CONV_W) + 1;
    localparam logic [DW-1:0]     MAX_DW     = DW'(10**DIGITS - 1);
    localparam logic [CONV_W-1:0] MAX_CW     = CONV_W'(10**DIGITS - 1);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CONV_W - 1);
    localparam logic [PTR_W-1:0]  LAST_CH    = PTR_W'(NCH - 1);
`ifdef IO_DISP_BLANK_EN
    localparam logic [6:0] HI_RST = 7'h7F;
`else
    localparam logic [6:0] HI_RST = 7'h40;
`endif

    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_STORE} state_t;

    state_t                    r_state, w_state_d;
    logic [DW-1:0]             r_regs  [NCH];
    logic [IN_W-1:0]           r_sync1 [NCH];
    logic [IN_W-1:0]           r_sync2 [NCH];
    logic [PTR_W-1:0]          r_ptr, w_ptr_d;
    logic [CNT_W-1:0]          r_cnt, w_cnt_d;
    logic [CONV_W-1:0]         r_bin, w_bin_d;
    logic [BCD_W-1:0]          r_bcd, w_bcd_d, w_bcd_adj;
    logic                      r_sat, w_sat_d;
    logic                      w_store;
    logic [DW-1:0]             w_snap;
    logic [NCH*DIGITS*7-1:0]   r_seg;
    logic [NCH-1:0]            r_ovf;
    logic                      r_frame_done;
    logic [DIGITS*7-1:0]       w_seg_ch;
    logic                      w_lead;
    logic [3:0]                w_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (32'(rd_addr) == k) rd_data = DW'(r_sync2[k]);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_bin_d   = r_bin;
        w_bcd_d   = r_bcd;
        w_sat_d   = r_sat;
        w_store   = 1'b0;
        w_snap    = r_regs[r_ptr];
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
        case (r_state)
            ST_LOAD: begin
                if (w_snap > MAX_DW) begin
                    w_sat_d = 1'b1;
                    w_bin_d = MAX_CW;
                end else begin
                    w_sat_d = 1'b0;
                    w_bin_d = w_snap[CONV_W-1:0];
                end
                w_bcd_d   = '0;
                w_cnt_d   = '0;
                w_state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_bcd_d = {w_bcd_adj[BCD_W-2:0], r_bin[CONV_W-1]};
                w_bin_d = {r_bin[CONV_W-2:0], 1'b0};
                w_cnt_d = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_SHIFT) w_state_d = ST_STORE;
            end
            ST_STORE: begin
                w_store   = 1'b1;
                w_ptr_d   = (r_ptr == LAST_CH) ? '0 : r_ptr + PTR_W'(1);
                w_state_d = ST_LOAD;
            end
            default: w_state_d = ST_LOAD;
        endcase
    end

    // Scan from the top digit down; w_lead stays set while only zeros have been seen.
    always_comb begin
        w_seg_ch = '0;
        w_lead   = 1'b1;
        w_digit  = '0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            w_digit = r_bcd[j*4 +: 4];
            if (w_digit != 4'd0) w_lead = 1'b0;
`ifdef IO_DISP_BLANK_EN
            w_seg_ch[j*7 +: 7] = (w_lead && j != 0) ? 7'h7F : seg7(w_digit);
`else
            w_seg_ch[j*7 +: 7] = seg7(w_digit);
`endif
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= ST_LOAD;
        else         r_state <= w_state_d;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_sat        <= 1'b0;
            r_ovf        <= '0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_regs[k]  <= '0;
                r_sync1[k] <= '0;
                r_sync2[k] <= '0;
                for (int j = 0; j < DIGITS; j++) begin
                    r_seg[(k*DIGITS+j)*7 +: 7] <= (j == 0) ? 7'h40 : HI_RST;
                end
            end
        end else begin
            r_ptr        <= w_ptr_d;
            r_cnt        <= w_cnt_d;
            r_bin        <= w_bin_d;
            r_bcd        <= w_bcd_d;
            r_sat        <= w_sat_d;
            r_frame_done <= w_store && (r_ptr == LAST_CH);
            for (int k = 0; k < NCH; k++) begin
                r_sync1[k] <= in_data[k*IN_W +: IN_W];
                r_sync2[k] <= r_sync1[k];
                if (wr_en && 32'(wr_addr) == k) r_regs[k] <= wr_data;
                if (w_store && 32'(r_ptr) == k) begin
                    r_seg[k*DIGITS*7 +: DIGITS*7] <= w_seg_ch;
                    r_ovf[k]                      <= r_sat;
                end
            end
        end
    end

    assign seg        = r_seg;
    assign ovf        = r_ovf;
    assign frame_done = r_frame_done;
endmodule
